mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares a single SRAM-like memory port between the instruction-fetch requester (I) and the data requester (D). D is the MEM/EXE load/store path.
- Arbitrates address phases, with D having fixed priority. Holds a granted request stable until it is accepted.
- Records the owner of every outstanding transaction in an in-order tag FIFO so that each data_ok/rdata goes back to the correct requester.
- Sits between the pipeline stages and the memory bridge.

Parameters:
- DEPTH, 4, maximum outstanding transactions (power of 2, at least 2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- i_req  in  1  instruction request valid
- i_wr  in  1  instruction write (always 0 in practice; still forwarded)
- i_size  in  2  transfer size
- i_wstrb  in  4  byte strobes
- i_addr  in  32  address
- i_wdata  in  32  write data
- i_addr_ok  out  1  instruction address phase accepted
- i_data_ok  out  1  instruction response valid
- i_rdata  out  32  instruction read data
- d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata  in  1/1/2/4/32/32  data requester, same meanings
- d_addr_ok  out  1  data address phase accepted
- d_data_ok  out  1  data response valid
- d_rdata  out  32  data read data
- m_req  out  1  downstream request
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/4/32/32  downstream request fields
- m_addr_ok  in  1  downstream accepted address phase
- m_data_ok  in  1  downstream response valid
- m_rdata  in  32  downstream read data
- outstanding  out  PTR_W+1  number of entries in the tag FIFO
- proto_err  out  1  sticky error flag

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low.
- Reset state: FIFO empty, outstanding=0, lock=0, proto_err=0. All outputs are combinationally 0 while the FIFO is empty and no req is present.
- Arbitration state: a 2-bit register {lock, lock_owner}.
  - UNLOCKED: if FIFO is not full, grant D when d_req=1; otherwise grant I when i_req=1; otherwise no grant.
  - Granted fields drive m_* combinationally and m_req=1.
  - If m_addr_ok=0 in that cycle, set lock=1 and lock_owner=granted.
  - LOCKED: the grant stays on lock_owner regardless of the other req (no preemption by D). The lock clears on the cycle m_addr_ok=1.
  - If the locked owner drops req (illegal), set proto_err, release the lock, and drive m_req=0 that cycle.
- Full FIFO (outstanding==DEPTH): m_req=0, both addr_ok=0. The lock is held if already set. A pop in the same cycle does not unblock; the grant resumes the next cycle.
- Accept: the handshake is m_req and m_addr_ok. In that cycle:
  - Assert addr_ok to the granted owner only, combinationally from m_addr_ok.
  - Push the owner tag (0=I, 1=D) into the FIFO tail.
  - Zero-cycle path: a request may be issued and accepted in the same cycle it first appears.
- Response: on m_data_ok, the head tag selects the target.
  - The target gets data_ok=1 and rdata=m_rdata in the same cycle (combinational). The other requester sees data_ok=0, rdata=0.
  - Pop the head.
  - Writes also return m_data_ok and are routed identically.
- Simultaneous push and pop (not full): the count is unchanged and both pointers advance. When count==1, the pushed tag becomes the head next cycle.
- m_data_ok with an empty FIFO: ignore (no pop, both data_ok=0) and set proto_err.
- Pointers wrap modulo DEPTH. outstanding is PTR_W+1 bits so that DEPTH is representable.
- proto_err stays set until reset.
- Reset mid-transaction clears all state. In-flight responses are not tracked after reset.

Decomposition:
- Shared header gets:
  - the tag encoding (TAG_INST=0, TAG_DATA=1);
  - the SRAM-like bundle widths (ADDR_W=32, DATA_W=32, SIZE_W=2, STRB_W=4).
- One sub-module, tag_fifo: a 1-bit-wide synchronous FIFO with push, pop, full, empty, count and head outputs, parameterised by DEPTH.

Test Plan:
- Reset, then d_req=1 at 0x1000 and i_req=1 at 0x1c000000 in the same cycle, with m_addr_ok=1 -> m_addr=0x1000, d_addr_ok=1, i_addr_ok=0. Next cycle I is granted; outstanding goes 1 then 2.
- i_req granted with m_addr_ok=0 for 3 cycles while d_req rises in cycle 2 -> m_addr stays the I address until accept (lock held); D is granted the cycle after.
- Issue I, D, I (tags 0,1,0), then m_data_ok with rdata 0xA, 0xB, 0xC -> i_rdata=0xA, d_rdata=0xB, i_rdata=0xC in order; outstanding returns to 0.
- Fill 4 outstanding with DEPTH=4 -> m_req=0 while d_req=1. Then m_data_ok arrives -> m_req stays 0 in that cycle and is reasserted the next cycle; outstanding goes 4, 3, 4.
- Simultaneous accept and response at outstanding=1 -> outstanding stays 1, and the new head is the pushed tag.
- m_data_ok with empty FIFO -> no data_ok pulses, proto_err=1 and sticky; assert resetn=0 for one cycle -> proto_err=0, outstanding=0.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the I/D memory request arbiter: tag encoding, bus widths
// and the arbitration state encoding {lock, lock_owner}.
package mem_req_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;

    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    // Upper bit is the lock flag, lower bit the owner tag of the locked request.
    typedef enum logic [1:0] {
        ARB_UNLOCKED = 2'b00,
        ARB_LOCK_I   = 2'b10,
        ARB_LOCK_D   = 2'b11
    } arb_state_e;

    function automatic arb_state_e lock_state(input logic owner);
        return (owner == TAG_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bundle. The master drives the address phase and
// receives addr_ok/data_ok/rdata; the slave is the opposite side.
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_req_arbiter_tag_fifo.sv
// 1-bit-wide in-order tag FIFO recording the owner of each outstanding transaction.
// The head is read combinationally so responses can be routed in the same cycle.
module mem_req_arbiter_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           push,
    input  logic           pop,
    input  logic           din,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count,
    output logic           head
);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             tag_reg [DEPTH];
    logic [DEPTH-1:0] entry_we;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) tag_reg[i] <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) tag_reg[i] <= din;
            end
        end
    end

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = tag_reg[rd_ptr_reg];

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch (I) and data (D) requesters,
// D having fixed priority; responses are routed back in order via the tag FIFO.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           resetn,
    mem_req_arbiter_if.slave  i_bus,
    mem_req_arbiter_if.slave  d_bus,
    mem_req_arbiter_if.master m_bus,
    output logic [PTR_W:0] outstanding,
    output logic           proto_err
);

    arb_state_e state_reg, state_next;
    logic       proto_err_reg, proto_err_next;
    logic       grant_valid, grant_owner, owner_req;
    logic       err_drop, err_empty;
    logic       push, pop;
    logic       fifo_full, fifo_empty, head_tag;
    logic       i_resp, d_resp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ARB_UNLOCKED;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            proto_err_reg <= proto_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        grant_owner = TAG_INST;
        owner_req   = 1'b0;
        err_drop    = 1'b0;
        case (state_reg)
            ARB_UNLOCKED: begin
                if (!fifo_full) begin
                    if (d_bus.req) begin
                        grant_valid = 1'b1;
                        grant_owner = TAG_DATA;
                    end else if (i_bus.req) begin
                        grant_valid = 1'b1;
                    end
                end
            end
            ARB_LOCK_I, ARB_LOCK_D: begin
                // A locked request may not be withdrawn; doing so is flagged and the lock dropped.
                grant_owner = (state_reg == ARB_LOCK_D) ? TAG_DATA : TAG_INST;
                owner_req   = (grant_owner == TAG_DATA) ? d_bus.req : i_bus.req;
                if (!owner_req) begin
                    err_drop   = 1'b1;
                    state_next = ARB_UNLOCKED;
                end else if (!fifo_full) begin
                    grant_valid = 1'b1;
                end
            end
            default: state_next = ARB_UNLOCKED;
        endcase
        if (grant_valid) begin
            state_next = m_bus.addr_ok ? ARB_UNLOCKED : lock_state(grant_owner);
        end
        push           = grant_valid && m_bus.addr_ok;
        pop            = m_bus.data_ok && !fifo_empty;
        err_empty      = m_bus.data_ok && fifo_empty;
        proto_err_next = proto_err_reg || err_drop || err_empty;
    end

    always_comb begin
        m_bus.req   = grant_valid;
        m_bus.wr    = 1'b0;
        m_bus.size  = '0;
        m_bus.wstrb = '0;
        m_bus.addr  = '0;
        m_bus.wdata = '0;
        if (grant_valid) begin
            if (grant_owner == TAG_DATA) begin
                m_bus.wr    = d_bus.wr;
                m_bus.size  = d_bus.size;
                m_bus.wstrb = d_bus.wstrb;
                m_bus.addr  = d_bus.addr;
                m_bus.wdata = d_bus.wdata;
            end else begin
                m_bus.wr    = i_bus.wr;
                m_bus.size  = i_bus.size;
                m_bus.wstrb = i_bus.wstrb;
                m_bus.addr  = i_bus.addr;
                m_bus.wdata = i_bus.wdata;
            end
        end
    end

    assign i_bus.addr_ok = push && (grant_owner == TAG_INST);
    assign d_bus.addr_ok = push && (grant_owner == TAG_DATA);

    assign i_resp        = pop && (head_tag == TAG_INST);
    assign d_resp        = pop && (head_tag == TAG_DATA);
    assign i_bus.data_ok = i_resp;
    assign d_bus.data_ok = d_resp;
    assign i_bus.rdata   = i_resp ? m_bus.rdata : '0;
    assign d_bus.rdata   = d_resp ? m_bus.rdata : '0;

    assign proto_err = proto_err_reg;

    mem_req_arbiter_tag_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (grant_owner),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outstanding),
        .head   (head_tag)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected owner tags are queued at each accept
// and popped to check routing when the memory side returns a response.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] outstanding;
    logic       proto_err;

    int   vectors = 0;
    int   miscompares = 0;
    logic sb_q [$];

    mem_req_arbiter_if i_bus ();
    mem_req_arbiter_if d_bus ();
    mem_req_arbiter_if m_bus ();

    mem_req_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_bus       (i_bus),
        .d_bus       (d_bus),
        .m_bus       (m_bus),
        .outstanding (outstanding),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_bus.req = 0; i_bus.wr = 0; i_bus.size = 2'd2; i_bus.wstrb = 4'h0;
        i_bus.addr = '0; i_bus.wdata = '0;
        d_bus.req = 0; d_bus.wr = 0; d_bus.size = 2'd2; d_bus.wstrb = 4'h0;
        d_bus.addr = '0; d_bus.wdata = '0;
        m_bus.addr_ok = 0; m_bus.data_ok = 0; m_bus.rdata = '0;
    endtask

    task automatic issue(input logic owner, input logic [31:0] addr);
        if (owner) begin
            d_bus.req = 1; d_bus.addr = addr; d_bus.wr = 1; d_bus.wstrb = 4'hf; d_bus.wdata = ~addr;
        end else begin
            i_bus.req = 1; i_bus.addr = addr;
        end
        m_bus.addr_ok = 1;
        #1;
        check_eq("issue_m_req", m_bus.req, 1);
        check_eq("issue_m_addr", m_bus.addr, addr);
        check_eq("issue_m_wr", m_bus.wr, owner);
        check_eq("issue_m_wdata", m_bus.wdata, owner ? ~addr : 32'h0);
        check_eq("issue_i_addr_ok", i_bus.addr_ok, !owner);
        check_eq("issue_d_addr_ok", d_bus.addr_ok, owner);
        $display("issue owner=%0d addr=0x%08h outstanding=%0d", owner, addr, outstanding);
        sb_q.push_back(owner);
        tick();
        i_bus.req = 0; d_bus.req = 0; d_bus.wr = 0; m_bus.addr_ok = 0;
    endtask

    // Inputs for a response must already be applied and settled.
    task automatic check_resp(input logic [31:0] rd);
        logic exp;
        if (sb_q.size() == 0) begin
            check_eq("sb_depth", sb_q.size(), 1);
        end else begin
            exp = sb_q.pop_front();
            check_eq("resp_i_data_ok", i_bus.data_ok, !exp);
            check_eq("resp_d_data_ok", d_bus.data_ok, exp);
            check_eq("resp_i_rdata", i_bus.rdata, exp ? 32'h0 : rd);
            check_eq("resp_d_rdata", d_bus.rdata, exp ? rd : 32'h0);
            $display("resp owner=%0d rdata=0x%08h", exp, rd);
        end
    endtask

    task automatic respond(input logic [31:0] rd);
        m_bus.data_ok = 1; m_bus.rdata = rd;
        #1;
        check_resp(rd);
        tick();
        m_bus.data_ok = 0; m_bus.rdata = '0;
    endtask

    task automatic do_reset();
        resetn = 0;
        tick();
        resetn = 1;
        sb_q.delete();
        #1;
    endtask

    initial begin
        idle_inputs();
        tick();
        do_reset();
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_proto_err", proto_err, 0);
        check_eq("rst_m_req", m_bus.req, 0);
        check_eq("rst_m_addr", m_bus.addr, 0);
        check_eq("rst_addr_ok", {i_bus.addr_ok, d_bus.addr_ok}, 0);
        check_eq("rst_data_ok", {i_bus.data_ok, d_bus.data_ok}, 0);

        // Simultaneous requests: D first, I the following cycle
        d_bus.req = 1; d_bus.addr = 32'h0000_1000;
        i_bus.req = 1; i_bus.addr = 32'h1c00_0000;
        m_bus.addr_ok = 1;
        #1;
        check_eq("prio_m_addr", m_bus.addr, 32'h0000_1000);
        check_eq("prio_d_addr_ok", d_bus.addr_ok, 1);
        check_eq("prio_i_addr_ok", i_bus.addr_ok, 0);
        sb_q.push_back(TAG_DATA);
        tick();
        d_bus.req = 0;
        #1;
        check_eq("prio2_m_addr", m_bus.addr, 32'h1c00_0000);
        check_eq("prio2_i_addr_ok", i_bus.addr_ok, 1);
        check_eq("prio2_outstanding", outstanding, 1);
        sb_q.push_back(TAG_INST);
        tick();
        i_bus.req = 0; m_bus.addr_ok = 0;
        #1;
        check_eq("prio3_outstanding", outstanding, 2);
        respond(32'h0000_0011);
        respond(32'h0000_0022);
        check_eq("prio_drain", outstanding, 0);

        // Lock: I held for three stalled cycles while D rises
        i_bus.req = 1; i_bus.addr = 32'h1c00_0040;
        #1;
        check_eq("lock0_m_addr", m_bus.addr, 32'h1c00_0040);
        check_eq("lock0_i_addr_ok", i_bus.addr_ok, 0);
        tick();
        d_bus.req = 1; d_bus.addr = 32'h0000_2000;
        #1;
        check_eq("lock1_m_addr", m_bus.addr, 32'h1c00_0040);
        check_eq("lock1_d_addr_ok", d_bus.addr_ok, 0);
        tick();
        check_eq("lock2_m_addr", m_bus.addr, 32'h1c00_0040);
        tick();
        m_bus.addr_ok = 1;
        #1;
        check_eq("lock3_m_addr", m_bus.addr, 32'h1c00_0040);
        check_eq("lock3_i_addr_ok", i_bus.addr_ok, 1);
        check_eq("lock3_d_addr_ok", d_bus.addr_ok, 0);
        sb_q.push_back(TAG_INST);
        tick();
        i_bus.req = 0;
        #1;
        check_eq("lock4_m_addr", m_bus.addr, 32'h0000_2000);
        check_eq("lock4_d_addr_ok", d_bus.addr_ok, 1);
        sb_q.push_back(TAG_DATA);
        tick();
        d_bus.req = 0; m_bus.addr_ok = 0;
        respond(32'h0000_0033);
        respond(32'h0000_0044);

        // In-order routing I, D, I
        issue(TAG_INST, 32'h1c00_0100);
        issue(TAG_DATA, 32'h0000_3000);
        issue(TAG_INST, 32'h1c00_0104);
        respond(32'h0000_000A);
        respond(32'h0000_000B);
        respond(32'h0000_000C);
        check_eq("order_drain", outstanding, 0);

        // Full FIFO blocks grants; a same-cycle pop does not unblock
        for (int k = 0; k < 4; k++) issue(TAG_DATA, 32'h0000_4000 + 32'(k * 4));
        d_bus.req = 1; d_bus.addr = 32'h0000_5000; m_bus.addr_ok = 1;
        #1;
        check_eq("full_m_req", m_bus.req, 0);
        check_eq("full_d_addr_ok", d_bus.addr_ok, 0);
        check_eq("full_outstanding", outstanding, 4);
        tick();
        m_bus.data_ok = 1; m_bus.rdata = 32'h0000_0100;
        #1;
        check_eq("fullpop_m_req", m_bus.req, 0);
        check_eq("fullpop_d_addr_ok", d_bus.addr_ok, 0);
        check_eq("fullpop_outstanding", outstanding, 4);
        check_resp(32'h0000_0100);
        tick();
        m_bus.data_ok = 0; m_bus.rdata = '0;
        #1;
        check_eq("resume_outstanding", outstanding, 3);
        check_eq("resume_m_req", m_bus.req, 1);
        check_eq("resume_m_addr", m_bus.addr, 32'h0000_5000);
        check_eq("resume_d_addr_ok", d_bus.addr_ok, 1);
        sb_q.push_back(TAG_DATA);
        tick();
        d_bus.req = 0; m_bus.addr_ok = 0;
        #1;
        check_eq("refill_outstanding", outstanding, 4);
        for (int k = 0; k < 4; k++) respond(32'h0000_0200 + 32'(k));

        // Push and pop together at count 1
        issue(TAG_INST, 32'h1c00_0200);
        d_bus.req = 1; d_bus.addr = 32'h0000_6000; m_bus.addr_ok = 1;
        m_bus.data_ok = 1; m_bus.rdata = 32'h0000_0055;
        #1;
        check_eq("pp_d_addr_ok", d_bus.addr_ok, 1);
        check_resp(32'h0000_0055);
        sb_q.push_back(TAG_DATA);
        tick();
        idle_inputs();
        #1;
        check_eq("pp_outstanding", outstanding, 1);
        respond(32'h0000_0066);
        check_eq("pp_drain", outstanding, 0);

        // Locked owner withdraws its request
        i_bus.req = 1; i_bus.addr = 32'h1c00_0300;
        tick();
        i_bus.req = 0; d_bus.req = 1; d_bus.addr = 32'h0000_7000;
        #1;
        check_eq("drop_m_req", m_bus.req, 0);
        check_eq("drop_proto_err_pre", proto_err, 0);
        tick();
        check_eq("drop_proto_err", proto_err, 1);
        check_eq("drop_d_granted", m_bus.req, 1);
        idle_inputs();
        do_reset();
        check_eq("drop_rst_proto_err", proto_err, 0);

        // Response with nothing outstanding
        m_bus.data_ok = 1; m_bus.rdata = 32'h0000_0077;
        #1;
        check_eq("empty_data_ok", {i_bus.data_ok, d_bus.data_ok}, 0);
        check_eq("empty_rdata", i_bus.rdata | d_bus.rdata, 0);
        tick();
        m_bus.data_ok = 0; m_bus.rdata = '0;
        check_eq("empty_proto_err", proto_err, 1);
        check_eq("empty_outstanding", outstanding, 0);
        tick();
        check_eq("sticky_proto_err", proto_err, 1);
        do_reset();
        check_eq("final_proto_err", proto_err, 0);
        check_eq("final_outstanding", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
